// File: rtl/acc_add_pkg.sv
// Shared definitions for the accumulate-on-keypress stage.
// Holds the default operand/accumulator widths, the FSM state type, and
// small helpers used by the top level. Import with: import acc_add_pkg::*;
package acc_add_pkg;

  // Default widths: 4-bit operand from the switches, 8-bit accumulator.
  localparam int OP_W_DEF  = 4;
  localparam int ACC_W_DEF = 8;

  // Controller states.
  //   ST_IDLE     : waiting for an add press
  //   ST_ADD      : single cycle in which the operand is accumulated
  //   ST_WAIT_REL : waiting for the add button to be released
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADD      = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  // The stage is busy whenever the controller has left IDLE.
  function automatic logic state_is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage : acc_add_pkg

// File: rtl/btn_sync_edge.sv
// Pushbutton conditioner: two-flop synchronizer followed by a third flop for
// falling-edge (press) detection on an active-low button.
//
// Reset loads every flop with the released level, so reset itself never
// produces a press. A button that is already held when reset is released
// must not register as a press either: the o_press output is gated by an
// "armed" flag that is only set once the synchronized level, sampled from
// the real pin (not the reset value), has been seen released.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level_n,
  output logic o_press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       w_level_real;

  // Synchronizer and edge-detect shift chain; released level is 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Track how many edges since reset; after two, r_sync2 carries a real pin sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= 2'b00;
    end else begin
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  assign w_level_real = r_fill[1];

  // Arm press detection once a genuine released level has been observed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
    end else if (w_level_real && r_sync2) begin
      r_armed <= 1'b1;
    end
  end

  assign o_level_n = r_sync2;
  // Press: synchronized level now asserted (low) while it was released one cycle ago.
  assign o_press   = r_armed & ~r_sync2 & r_prev;

endmodule : btn_sync_edge

// File: rtl/acc_add_stage.sv
// Accumulate-on-keypress stage.
//
// Each accepted press of KEY_ADD_N adds the zero-extended SW operand to the
// registered accumulator (LEDR). CARRY is a sticky flag set whenever an
// addition overflows ACC_W bits; only a clear press or reset clears it.
// Holding the add button yields exactly one addition: the controller waits
// in ST_WAIT_REL until the synchronized button is released.
//
// Handshake: there is no valid/ready pair here; a "press" is a one-cycle
// pulse from btn_sync_edge, consumed in the cycle it is high and otherwise
// dropped (presses arriving outside ST_IDLE are ignored by design).
//
// Clear has priority: a clear pulse zeroes LEDR and CARRY at the next edge
// in any state. If the clear pulse coincides with the add press that starts
// a transaction, the controller still walks ADD -> WAIT_REL but the pending
// addition is cancelled (r_kill), so the clear is not undone one cycle later.
//
// Build option: define ACC_SATURATE_EN to clamp LEDR to all-ones on overflow
// instead of wrapping modulo 2^ACC_W. CARRY behaves identically either way.
//
// ACC_W must be at least OP_W+1.
module acc_add_stage
  import acc_add_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY_ADD_N,
  input  logic             KEY_CLR_N,
  input  logic [OP_W-1:0]  SW,
  output logic [ACC_W-1:0] LEDR,
  output logic             CARRY,
  output logic             BUSY,
  output state_t           o_dbg_state
);

  // Button conditioning outputs.
  logic w_add_level_n;
  logic w_add_press;
  logic w_clr_level_n;
  logic w_clr_press;

  // Controller state.
  state_t r_state;
  state_t w_next_state;

  // Datapath.
  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic             r_kill;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_add_en;

  btn_sync_edge u_add_btn (
    .i_clk     (CLOCK_50),
    .i_rst_n   (RESET_N),
    .i_btn_n   (KEY_ADD_N),
    .o_level_n (w_add_level_n),
    .o_press   (w_add_press)
  );

  btn_sync_edge u_clr_btn (
    .i_clk     (CLOCK_50),
    .i_rst_n   (RESET_N),
    .i_btn_n   (KEY_CLR_N),
    .o_level_n (w_clr_level_n),
    .o_press   (w_clr_press)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one ADD cycle per press, then hold until release.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_add_press) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        w_next_state = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (w_add_level_n) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    BUSY        = state_is_busy(r_state);
    o_dbg_state = r_state;
  end

  // Adder: one guard bit above the accumulator captures overflow.
  always_comb begin
    w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(SW);
`ifdef ACC_SATURATE_EN
    w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    w_acc_next = w_sum[ACC_W-1:0];
`endif
    w_add_en = (r_state == ST_ADD) && !r_kill;
  end

  // Remember a clear that arrived together with the press that starts a transaction.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kill <= 1'b0;
    end else begin
      r_kill <= w_clr_press && w_add_press && (r_state == ST_IDLE);
    end
  end

  // Accumulator and sticky carry; clear wins over any addition.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_clr_press) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_add_en) begin
      r_acc <= w_acc_next;
      if (w_sum[ACC_W]) begin
        r_carry <= 1'b1;
      end
    end
  end

  assign LEDR  = r_acc;
  assign CARRY = r_carry;

  // The clear button level is only needed as a press; keep it observable-free.
  logic w_unused;
  assign w_unused = w_clr_level_n;

endmodule : acc_add_stage

// File: tb/tb_acc_add_stage.sv
// Bench for acc_add_stage: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model of the stage.
module tb_acc_add_stage;
  import acc_add_pkg::*;

  localparam int OP_W  = 4;
  localparam int ACC_W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_add_n = 1'b1;
  logic             key_clr_n = 1'b1;
  logic [OP_W-1:0]  sw = '0;
  logic [ACC_W-1:0] ledr;
  logic             carry;
  logic             busy;
  state_t           dbg_state;

  always #5 clk = ~clk;

  acc_add_stage #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY_ADD_N   (key_add_n),
    .KEY_CLR_N   (key_clr_n),
    .SW          (sw),
    .LEDR        (ledr),
    .CARRY       (carry),
    .BUSY        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button pin history: hist[0] = pin sampled one edge ago, etc.
  // A button is "seen" by the controller two edges after the pin moves;
  // a press is the seen level going low after being high, counted only after
  // the button has been observed released since reset.
  bit a_hist[3];
  bit c_hist[3];
  int edges_since_reset;
  bit a_ok, c_ok;
  int m_acc;
  bit m_carry;
  int m_phase;      // 0 idle, 1 adding, 2 waiting for release
  bit m_cancel;     // clear came with the starting press: skip the add

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      a_hist[i] = 1'b1;
      c_hist[i] = 1'b1;
    end
    edges_since_reset = 0;
    a_ok = 1'b0;
    c_ok = 1'b0;
    m_acc = 0;
    m_carry = 1'b0;
    m_phase = 0;
    m_cancel = 1'b0;
  endtask

  // Advance the model across one rising edge with the present inputs.
  task automatic model_step(input bit a, input bit c, input int s);
    bit a_seen, a_was, c_seen, c_was, pa, pc, next_cancel;
    int sum, next_phase;
    a_seen = a_hist[1];
    a_was  = a_hist[2];
    c_seen = c_hist[1];
    c_was  = c_hist[2];
    pa = a_ok && !a_seen && a_was;
    pc = c_ok && !c_seen && c_was;

    next_cancel = pa && pc && (m_phase == 0);
    if (pc) begin
      m_acc = 0;
      m_carry = 1'b0;
    end else if (m_phase == 1 && !m_cancel) begin
      sum = m_acc + s;
      if (sum >= 256) m_carry = 1'b1;
`ifdef ACC_SATURATE_EN
      m_acc = (sum >= 256) ? 255 : sum;
`else
      m_acc = sum % 256;
`endif
    end
    m_cancel = next_cancel;

    case (m_phase)
      0: next_phase = pa ? 1 : 0;
      1: next_phase = 2;
      default: next_phase = a_seen ? 0 : 2;
    endcase
    m_phase = next_phase;

    if (edges_since_reset >= 2 && a_seen) a_ok = 1'b1;
    if (edges_since_reset >= 2 && c_seen) c_ok = 1'b1;
    edges_since_reset++;
    a_hist[2] = a_hist[1];
    a_hist[1] = a_hist[0];
    a_hist[0] = a;
    c_hist[2] = c_hist[1];
    c_hist[1] = c_hist[0];
    c_hist[0] = c;
  endtask

  task automatic compare_all(input string tag);
    state_t exp_st;
    exp_st = (m_phase == 0) ? ST_IDLE : (m_phase == 1) ? ST_ADD : ST_WAIT_REL;
    check({tag, "_ledr"},  32'(ledr),      32'(m_acc));
    check({tag, "_carry"}, 32'(carry),     32'(m_carry));
    check({tag, "_busy"},  32'(busy),      32'(m_phase != 0));
    check({tag, "_state"}, 32'(dbg_state), 32'(exp_st));
  endtask

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic cycle(input bit a, input bit c, input int s, input string tag);
    key_add_n = a;
    key_clr_n = c;
    sw = OP_W'(s);
    model_step(a, c, s);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic press_add(input int s);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, s, "padd");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, s, "prel");
  endtask

  task automatic press_clr();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, "pclr");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 0, "pclr_rel");
  endtask

  // ---------------- stimulus ----------------
  bit ra, rc;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 0, "idle");

    // Single press held 10 cycles: one update, visible at the 4th edge.
    cycle(1'b0, 1'b1, 5, "lat1");
    cycle(1'b0, 1'b1, 5, "lat2");
    cycle(1'b0, 1'b1, 5, "lat3");
    check("lat_before_e4", 32'(ledr), 32'h00);
    check("lat_busy_e3", 32'(busy), 32'h1);
    cycle(1'b0, 1'b1, 5, "lat4");
    check("lat_at_e4", 32'(ledr), 32'h05);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 5, "hold");
    check("hold_single", 32'(ledr), 32'h05);
    check("hold_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5, "rel");
    check("rel_idle", 32'(busy), 32'h0);

    // Overflow from 0xFE.
    press_clr();
    for (int i = 0; i < 16; i++) press_add(15);
    press_add(14);
    check("pre_ovf", 32'(ledr), 32'hFE);
    press_add(3);
`ifdef ACC_SATURATE_EN
    check("ovf_ledr", 32'(ledr), 32'hFF);
`else
    check("ovf_ledr", 32'(ledr), 32'h01);
`endif
    check("ovf_carry", 32'(carry), 32'h1);

    // Clear with carry set, then add again.
`ifndef ACC_SATURATE_EN
    for (int i = 0; i < 4; i++) press_add(15);
    press_add(3);
    check("pre_clr", 32'(ledr), 32'h40);
`endif
    check("pre_clr_carry", 32'(carry), 32'h1);
    press_clr();
    check("clr_ledr", 32'(ledr), 32'h00);
    check("clr_carry", 32'(carry), 32'h0);
    press_add(2);
    check("post_clr_add", 32'(ledr), 32'h02);
    check("post_clr_carry", 32'(carry), 32'h0);

    // Add and clear pressed together from 0x10.
    press_clr();
    press_add(15);
    press_add(1);
    check("pre_both", 32'(ledr), 32'h10);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1, "both");
    check("both_state", 32'(dbg_state), 32'(ST_WAIT_REL));
    check("both_ledr", 32'(ledr), 32'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1, "both_hold");
    check("both_noadd", 32'(ledr), 32'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1, "both_rel");

    // Reset in the middle of an ADD with the button kept held.
    press_add(15);
    press_add(15);
    press_add(2);
    check("pre_rst", 32'(ledr), 32'h20);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4, "to_add");
    check("in_add", 32'(dbg_state), 32'(ST_ADD));
    do_reset(2);
    check("rst_ledr", 32'(ledr), 32'h00);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4, "held_after_rst");
    check("held_no_press", 32'(busy), 32'h0);
    check("held_no_add", 32'(ledr), 32'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4, "rel_after_rst");
    press_add(4);
    check("repress", 32'(ledr), 32'h04);

    // Random button traffic with occasional resets.
    ra = 1'b1;
    rc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 11) == 0) rc = ~rc;
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 2));
      end else begin
        cycle(ra, rc, int'($urandom_range(0, 15)), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_acc_add_stage
